// File: rtl/db_pkg.sv
// Shared definitions for the debouncer / key-repeat pair: FSM encodings and
// default timing constants for a 50 MHz system clock.
package db_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    localparam int TICK_DIV_50MHZ_10MS = 500000;
    localparam int DELAY_TICKS_500MS   = 50;
    localparam int RATE_TICKS_100MS    = 10;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and emits a one-cycle tick on the
// terminal count. A synchronous clear parks it at zero.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign tick_o = en_i && !clr_i && (presc_q == LAST);

    always_comb begin
        presc_d = presc_q;
        if (clr_i) begin
            presc_d = '0;
        end else if (en_i) begin
            presc_d = tick_o ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/key_repeat.sv
// Turns a debounced key level into press / release pulses plus typematic
// repeat pulses while the key is held (initial delay, then a fixed rate).
module key_repeat
    import db_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_50MHZ_10MS,
    parameter int DELAY_TICKS = DELAY_TICKS_500MS,
    parameter int RATE_TICKS  = RATE_TICKS_100MS
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic db_i,
    output logic press_o,
    output logic release_o,
    output logic rpt_o,
    output logic key_evt_o,
    output logic held_o
);

    localparam int            CW      = $clog2(max2(DELAY_TICKS, RATE_TICKS) + 1);
    localparam logic [CW-1:0] DELAY_C = CW'(DELAY_TICKS);
    localparam logic [CW-1:0] RATE_C  = CW'(RATE_TICKS);

    state_e        state_q;
    logic          db_q;
    logic          rise;
    logic          fall;
    logic          tick;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic          press_q;
    logic          release_q;
    logic          rpt_q;
    logic          held_q;

    assign rise    = db_i & ~db_q;
    assign fall    = ~db_i & db_q;
    assign cnt_inc = cnt_q + CW'(1);

    // Prescaler is parked at zero in IDLE so timing restarts from each press.
    tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clr_i  (state_q == ST_IDLE),
        .en_i   (state_q != ST_IDLE),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            db_q      <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rpt_q     <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            db_q      <= db_i;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rpt_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q <= ST_DELAY;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    // A fall wins over a repeat falling due in the same cycle.
                    if (fall) begin
                        state_q   <= ST_IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        cnt_q     <= '0;
                    end else if (tick) begin
                        if (cnt_inc == ((state_q == ST_DELAY) ? DELAY_C : RATE_C)) begin
                            state_q <= ST_REPEAT;
                            rpt_q   <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    held_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign rpt_o     = rpt_q;
    assign key_evt_o = press_q | rpt_q;
    assign held_o    = held_q;

endmodule

// File: tb/tb_key_repeat.sv
// Directed bench for key_repeat with TICK_DIV=4, DELAY_TICKS=3, RATE_TICKS=2:
// first repeat 12 cycles after press, then every 8 cycles.
module tb_key_repeat;

    localparam int TICK_DIV    = 4;
    localparam int DELAY_TICKS = 3;
    localparam int RATE_TICKS  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic db    = 1'b0;
    logic press;
    logic rel;
    logic rpt;
    logic key_evt;
    logic held;
    logic [4:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    key_repeat #(
        .TICK_DIV   (TICK_DIV),
        .DELAY_TICKS(DELAY_TICKS),
        .RATE_TICKS (RATE_TICKS)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .db_i     (db),
        .press_o  (press),
        .release_o(rel),
        .rpt_o    (rpt),
        .key_evt_o(key_evt),
        .held_o   (held)
    );

    always #5 clk = ~clk;

    // Observation vector: {press, release, rpt, key_evt, held}
    assign obs = {press, rel, rpt, key_evt, held};

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {p,r,rpt,evt,held}=%b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ev(input bit p, input bit r, input bit t, input bit h);
        return {p, r, t, p | t, h};
    endfunction

    // Hand-derived schedule: repeats at C0+12, then every 8 cycles.
    function automatic bit rpt_due(input int k);
        return (k >= 12) && (((k - 12) % 8) == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Key already driven high; observe cycles C0..C0+n-1.
    task automatic hold_check(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            step();
            check($sformatf("%s C0+%0d", tag, k), obs, ev(k == 0, 1'b0, rpt_due(k), 1'b1));
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            step();
            check($sformatf("%s idle%0d", tag, k), obs, 5'b00000);
        end
    endtask

    task automatic release_check(input string tag);
        db = 1'b0;
        step();
        check({tag, " release"}, obs, ev(1'b0, 1'b1, 1'b0, 1'b0));
    endtask

    initial begin
        // Reset with db low, then idle
        step();
        step();
        check("reset", obs, 5'b00000);
        reset = 1'b0;
        idle_check("idle50", 50);
        $display("[TB] reset/idle done");

        // Long hold: press then repeats at 12, 20, 28, 36
        db = 1'b1;
        hold_check("hold40", 40);
        release_check("hold40");
        idle_check("hold40", 5);
        $display("[TB] hold40 done");

        // Short hold, released before any repeat
        db = 1'b1;
        hold_check("short", 11);
        release_check("short");
        idle_check("short", 20);
        $display("[TB] short hold done");

        // Fall sampled exactly when the first repeat is due
        db = 1'b1;
        hold_check("clash12", 12);
        release_check("clash12");
        idle_check("clash12", 12);
        $display("[TB] clash at first repeat done");

        // Fall sampled exactly when the second repeat is due
        db = 1'b1;
        hold_check("clash20", 20);
        release_check("clash20");
        idle_check("clash20", 10);
        $display("[TB] clash at second repeat done");

        // Async reset mid-hold, db stays high across it
        db = 1'b1;
        hold_check("prereset", 16);
        #2 reset = 1'b1;
        #1 check("reset async", obs, 5'b00000);
        step();
        check("reset hold0", obs, 5'b00000);
        step();
        check("reset hold1", obs, 5'b00000);
        reset = 1'b0;
        hold_check("postreset", 21);
        $display("[TB] reset mid-hold done");

        // Fall then rise on consecutive cycles
        release_check("bounce");
        db = 1'b1;
        hold_check("bounce", 22);
        release_check("final");
        idle_check("final", 3);
        $display("[TB] fall/rise back-to-back done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
